// File: rtl/mips_define.sv
// Shared MIPS64 encoding definitions.
// Holds the major-opcode and funct field values, the symbolic mnemonic
// enum (enc_op_t) accepted by the encoder, the encoder format classes,
// the encoder FSM state type, and small lookup helpers that map a
// mnemonic to its format class and numeric field values.
package mips_define;

    // Major opcode field [31:26]
    localparam logic [5:0] OP_OTHER0 = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_Z0     = 6'h10;
    localparam logic [5:0] OP_DADDI  = 6'h18;
    localparam logic [5:0] OP_DADDIU = 6'h19;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LWU    = 6'h27;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] OP_LD     = 6'h37;
    localparam logic [5:0] OP_SD     = 6'h3F;

    // COP0 "CO" bit (bit 25) and the ERET function code
    localparam logic       OP_CO    = 1'b1;
    localparam logic [5:0] OPC_ERET = 6'h18;

    // SPECIAL funct field [5:0]
    localparam logic [5:0] FUNCT_SLL     = 6'h00;
    localparam logic [5:0] FUNCT_SRL     = 6'h02;
    localparam logic [5:0] FUNCT_SRA     = 6'h03;
    localparam logic [5:0] FUNCT_JR      = 6'h08;
    localparam logic [5:0] FUNCT_JALR    = 6'h09;
    localparam logic [5:0] FUNCT_SYSCALL = 6'h0C;
    localparam logic [5:0] FUNCT_ADD     = 6'h20;
    localparam logic [5:0] FUNCT_ADDU    = 6'h21;
    localparam logic [5:0] FUNCT_SUB     = 6'h22;
    localparam logic [5:0] FUNCT_SUBU    = 6'h23;
    localparam logic [5:0] FUNCT_AND     = 6'h24;
    localparam logic [5:0] FUNCT_OR      = 6'h25;
    localparam logic [5:0] FUNCT_XOR     = 6'h26;
    localparam logic [5:0] FUNCT_NOR     = 6'h27;
    localparam logic [5:0] FUNCT_SLT     = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU    = 6'h2B;
    localparam logic [5:0] FUNCT_DADD    = 6'h2C;
    localparam logic [5:0] FUNCT_DADDU   = 6'h2D;
    localparam logic [5:0] FUNCT_DSUB    = 6'h2E;

    // Symbolic mnemonics; any 6-bit value outside this list is illegal.
    typedef enum logic [5:0] {
        ENC_ADD, ENC_ADDU, ENC_SUB, ENC_SUBU, ENC_AND, ENC_OR, ENC_XOR,
        ENC_NOR, ENC_SLT, ENC_SLTU, ENC_SLL, ENC_SRL, ENC_SRA, ENC_JR,
        ENC_JALR, ENC_DADD, ENC_DADDU, ENC_DSUB,
        ENC_ADDI, ENC_ADDIU, ENC_DADDI, ENC_DADDIU, ENC_SLTI, ENC_SLTIU,
        ENC_ANDI, ENC_ORI, ENC_XORI, ENC_LUI, ENC_BEQ, ENC_BNE, ENC_LB,
        ENC_LBU, ENC_LW, ENC_LWU, ENC_LD, ENC_SB, ENC_SW, ENC_SD,
        ENC_J, ENC_JAL,
        ENC_SYSCALL, ENC_ERET,
        ENC_NOP, ENC_LI
    } enc_op_t;

    // Format classes
    localparam logic [2:0] FMT_R      = 3'd0;
    localparam logic [2:0] FMT_I      = 3'd1;
    localparam logic [2:0] FMT_J      = 3'd2;
    localparam logic [2:0] FMT_FIXED  = 3'd3;
    localparam logic [2:0] FMT_PSEUDO = 3'd4;
    localparam logic [2:0] FMT_NONE   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_PEND
    } enc_state_t;

    function automatic logic [2:0] enc_fmt(input logic [5:0] op);
        case (op)
            ENC_ADD, ENC_ADDU, ENC_SUB, ENC_SUBU, ENC_AND, ENC_OR, ENC_XOR,
            ENC_NOR, ENC_SLT, ENC_SLTU, ENC_SLL, ENC_SRL, ENC_SRA, ENC_JR,
            ENC_JALR, ENC_DADD, ENC_DADDU, ENC_DSUB:           return FMT_R;
            ENC_ADDI, ENC_ADDIU, ENC_DADDI, ENC_DADDIU, ENC_SLTI, ENC_SLTIU,
            ENC_ANDI, ENC_ORI, ENC_XORI, ENC_LUI, ENC_BEQ, ENC_BNE, ENC_LB,
            ENC_LBU, ENC_LW, ENC_LWU, ENC_LD, ENC_SB, ENC_SW,
            ENC_SD:                                            return FMT_I;
            ENC_J, ENC_JAL:                                    return FMT_J;
            ENC_SYSCALL, ENC_ERET:                             return FMT_FIXED;
            ENC_NOP, ENC_LI:                                   return FMT_PSEUDO;
            default:                                           return FMT_NONE;
        endcase
    endfunction

    function automatic logic [5:0] r_funct(input logic [5:0] op);
        case (op)
            ENC_ADD:   return FUNCT_ADD;
            ENC_ADDU:  return FUNCT_ADDU;
            ENC_SUB:   return FUNCT_SUB;
            ENC_SUBU:  return FUNCT_SUBU;
            ENC_AND:   return FUNCT_AND;
            ENC_OR:    return FUNCT_OR;
            ENC_XOR:   return FUNCT_XOR;
            ENC_NOR:   return FUNCT_NOR;
            ENC_SLT:   return FUNCT_SLT;
            ENC_SLTU:  return FUNCT_SLTU;
            ENC_SLL:   return FUNCT_SLL;
            ENC_SRL:   return FUNCT_SRL;
            ENC_SRA:   return FUNCT_SRA;
            ENC_JR:    return FUNCT_JR;
            ENC_JALR:  return FUNCT_JALR;
            ENC_DADD:  return FUNCT_DADD;
            ENC_DADDU: return FUNCT_DADDU;
            ENC_DSUB:  return FUNCT_DSUB;
            default:   return 6'h00;
        endcase
    endfunction

    // Major opcode for I-type and J-type mnemonics
    function automatic logic [5:0] major_op(input logic [5:0] op);
        case (op)
            ENC_ADDI:   return OP_ADDI;
            ENC_ADDIU:  return OP_ADDIU;
            ENC_DADDI:  return OP_DADDI;
            ENC_DADDIU: return OP_DADDIU;
            ENC_SLTI:   return OP_SLTI;
            ENC_SLTIU:  return OP_SLTIU;
            ENC_ANDI:   return OP_ANDI;
            ENC_ORI:    return OP_ORI;
            ENC_XORI:   return OP_XORI;
            ENC_LUI:    return OP_LUI;
            ENC_BEQ:    return OP_BEQ;
            ENC_BNE:    return OP_BNE;
            ENC_LB:     return OP_LB;
            ENC_LBU:    return OP_LBU;
            ENC_LW:     return OP_LW;
            ENC_LWU:    return OP_LWU;
            ENC_LD:     return OP_LD;
            ENC_SB:     return OP_SB;
            ENC_SW:     return OP_SW;
            ENC_SD:     return OP_SD;
            ENC_J:      return OP_J;
            ENC_JAL:    return OP_JAL;
            default:    return OP_OTHER0;
        endcase
    endfunction

endpackage

// File: rtl/mips_encode_word.sv
// Combinational MIPS64 instruction encoder.
// Maps one symbolic request to up to two 32-bit words.
//   op          : enc_op_t mnemonic (raw 6 bits; unknown values flagged)
//   rs/rt/rd/shamt : register and shift fields
//   imm         : imm16 in [15:0], J target in [25:0], LI constant in [31:0]
//   word        : first (or only) encoded word; NOP for an unknown op
//   second_word : ORI half of a two-word LI
//   two_words   : second_word is meaningful
//   illegal     : op is not a known mnemonic
module mips_encode_word
    import mips_define::*;
(
    input  logic [5:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic [31:0] second_word,
    output logic        two_words,
    output logic        illegal
);

    logic [15:0] imm_hi;
    logic [15:0] imm_lo;

    assign imm_hi = imm[31:16];
    assign imm_lo = imm[15:0];

    always_comb begin
        word        = 32'h0;
        second_word = 32'h0;
        two_words   = 1'b0;
        illegal     = 1'b0;
        case (enc_fmt(op))
            FMT_R: word = {OP_OTHER0, rs, rt, rd, shamt, r_funct(op)};
            FMT_I: word = {major_op(op), rs, rt, imm_lo};
            FMT_J: word = {major_op(op), imm[25:0]};
            FMT_FIXED: begin
                if (op == ENC_ERET)
                    word = {OP_Z0, OP_CO, 19'b0, OPC_ERET};
                else
                    word = {OP_OTHER0, 20'b0, FUNCT_SYSCALL};
            end
            FMT_PSEUDO: begin
                if (op == ENC_LI) begin
                    if (imm_hi == 16'h0) begin
                        // Fits in 16 bits: ORI from $zero is enough
                        word = {OP_ORI, 5'd0, rt, imm_lo};
                    end else begin
                        // LUI sets the upper half and clears the lower,
                        // so the ORI is only needed for a nonzero low half
                        word        = {OP_LUI, 5'd0, rt, imm_hi};
                        second_word = {OP_ORI, rt, rt, imm_lo};
                        two_words   = (imm_lo != 16'h0);
                    end
                end
                // NOP keeps the all-zero default word
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_insn_encoder.sv
// Streaming MIPS64 instruction encoder / program loader.
// Accepts symbolic requests on a valid/ready input, emits encoded words
// paired with an auto-incrementing instruction-memory address, and expands
// the LI (one or two words) and NOP pseudo-ops.
//   clock, reset    : rising-edge clock, synchronous active-high reset
//   restart         : reload the address counter to BASE_ADDR, clear err
//   in_valid/in_ready, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm
//                   : request channel
//   out_valid/out_ready, out_word, out_addr
//                   : encoded word channel
//   err             : sticky, set when an unknown op is accepted
module mips_insn_encoder
    import mips_define::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int          ADDR_W    = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err
);

    localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];

    enc_state_t        state, state_nxt;
    logic [31:0]       pend_word;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] load_addr;

    logic [31:0] enc_word, enc_second;
    logic        enc_two, enc_illegal;

    logic accept, out_fire, load_pend;

    mips_encode_word u_encode (
        .op          (in_op),
        .rs          (in_rs),
        .rt          (in_rt),
        .rd          (in_rd),
        .shamt       (in_shamt),
        .imm         (in_imm),
        .word        (enc_word),
        .second_word (enc_second),
        .two_words   (enc_two),
        .illegal     (enc_illegal)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = enc_two ? S_PEND : S_HOLD;
            end
            S_HOLD: begin
                if (accept)        state_nxt = enc_two ? S_PEND : S_HOLD;
                else if (out_fire) state_nxt = S_IDLE;
            end
            S_PEND: begin
                if (out_fire) state_nxt = S_HOLD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs and load strobes
    always_comb begin
        out_valid = (state != S_IDLE);
        in_ready  = (state != S_PEND) && (!out_valid || out_ready);
        accept    = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        load_pend = (state == S_PEND) && out_fire;
        load_addr = restart ? BASE : addr_cnt;
    end

    // Datapath. addr_cnt holds the address the next loaded word will get.
    // Every loaded word leaves through exactly one out handshake (reset
    // discards both together), so stepping on load assigns the same
    // addresses as stepping on handshake while letting a restart apply
    // cleanly to whichever word loads next -- including a pending ORI.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_word  <= 32'h0;
            out_addr  <= BASE;
            pend_word <= 32'h0;
            addr_cnt  <= BASE;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                out_word  <= enc_word;
                pend_word <= enc_second;
            end else if (load_pend) begin
                out_word <= pend_word;
            end

            if (accept || load_pend) begin
                out_addr <= load_addr;
                addr_cnt <= load_addr + ADDR_W'(4);
            end else if (restart) begin
                addr_cnt <= BASE;
            end

            // A simultaneous illegal accept beats the restart clear
            if (accept && enc_illegal) err <= 1'b1;
            else if (restart)          err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_insn_encoder.sv
// Testbench for mips_insn_encoder: directed scenarios plus a randomized
// stream, with a queue scoreboard fed at accept time and drained by an
// independent output monitor.
module tb_mips_insn_encoder;
    import mips_define::*;

    localparam logic [63:0] BASE = 64'h0000_0000_BFC0_0000;

    logic        clock = 1'b0;
    logic        reset, restart, in_valid, in_ready, out_valid, out_ready, err;
    logic [5:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [31:0] in_imm, out_word;
    logic [63:0] out_addr;

    always #5 clock = ~clock;

    mips_insn_encoder #(.BASE_ADDR(BASE), .ADDR_W(64)) dut (
        .clock     (clock),
        .reset     (reset),
        .restart   (restart),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_shamt  (in_shamt),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_addr  (out_addr),
        .err       (err)
    );

    typedef struct packed {
        logic [31:0] w;
        logic [63:0] a;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_addr;
    logic        exp_err;
    logic [5:0]  legal[$];
    bit          legal_map[64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    // Reference model: list of words a request produces, from the ISA
    // field layout with plain arithmetic.
    function automatic void ref_enc(input logic [5:0] op, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic [4:0] rd,
                                    input logic [4:0] sh, input logic [31:0] imm,
                                    output logic [31:0] w0, output logic [31:0] w1,
                                    output int n, output bit bad);
        logic [31:0] f, o, hi, lo, s, t, d, a;
        int kind; // 0 R, 1 I, 2 J, 3 literal word, 4 LI, 5 unknown
        f = 0; o = 0; kind = 3; n = 1; bad = 0; w0 = 0; w1 = 0;
        hi = imm / 65536; lo = imm % 65536;
        s = 32'(rs); t = 32'(rt); d = 32'(rd); a = 32'(sh);
        case (op)
            ENC_ADD:   begin kind = 0; f = 32; end
            ENC_ADDU:  begin kind = 0; f = 33; end
            ENC_SUB:   begin kind = 0; f = 34; end
            ENC_SUBU:  begin kind = 0; f = 35; end
            ENC_AND:   begin kind = 0; f = 36; end
            ENC_OR:    begin kind = 0; f = 37; end
            ENC_XOR:   begin kind = 0; f = 38; end
            ENC_NOR:   begin kind = 0; f = 39; end
            ENC_SLT:   begin kind = 0; f = 42; end
            ENC_SLTU:  begin kind = 0; f = 43; end
            ENC_SLL:   begin kind = 0; f = 0;  end
            ENC_SRL:   begin kind = 0; f = 2;  end
            ENC_SRA:   begin kind = 0; f = 3;  end
            ENC_JR:    begin kind = 0; f = 8;  end
            ENC_JALR:  begin kind = 0; f = 9;  end
            ENC_DADD:  begin kind = 0; f = 44; end
            ENC_DADDU: begin kind = 0; f = 45; end
            ENC_DSUB:  begin kind = 0; f = 46; end
            ENC_ADDI:   begin kind = 1; o = 8;  end
            ENC_ADDIU:  begin kind = 1; o = 9;  end
            ENC_DADDI:  begin kind = 1; o = 24; end
            ENC_DADDIU: begin kind = 1; o = 25; end
            ENC_SLTI:   begin kind = 1; o = 10; end
            ENC_SLTIU:  begin kind = 1; o = 11; end
            ENC_ANDI:   begin kind = 1; o = 12; end
            ENC_ORI:    begin kind = 1; o = 13; end
            ENC_XORI:   begin kind = 1; o = 14; end
            ENC_LUI:    begin kind = 1; o = 15; end
            ENC_BEQ:    begin kind = 1; o = 4;  end
            ENC_BNE:    begin kind = 1; o = 5;  end
            ENC_LB:     begin kind = 1; o = 32; end
            ENC_LBU:    begin kind = 1; o = 36; end
            ENC_LW:     begin kind = 1; o = 35; end
            ENC_LWU:    begin kind = 1; o = 39; end
            ENC_LD:     begin kind = 1; o = 55; end
            ENC_SB:     begin kind = 1; o = 40; end
            ENC_SW:     begin kind = 1; o = 43; end
            ENC_SD:     begin kind = 1; o = 63; end
            ENC_J:      begin kind = 2; o = 2;  end
            ENC_JAL:    begin kind = 2; o = 3;  end
            ENC_SYSCALL: w0 = 32'h0000_000C;
            ENC_ERET:    w0 = 32'h4200_0018;
            ENC_NOP:     w0 = 32'h0;
            ENC_LI:      kind = 4;
            default:     begin kind = 5; bad = 1; end
        endcase
        case (kind)
            0: w0 = s * 2097152 + t * 65536 + d * 2048 + a * 64 + f;
            1: w0 = o * 67108864 + s * 2097152 + t * 65536 + lo;
            2: w0 = o * 67108864 + imm % 67108864;
            4: begin
                if (hi == 0) begin
                    w0 = 13 * 67108864 + t * 65536 + lo;
                end else begin
                    w0 = 15 * 67108864 + t * 65536 + hi;
                    if (lo != 0) begin
                        n  = 2;
                        w1 = 13 * 67108864 + t * 2097152 + t * 65536 + lo;
                    end
                end
            end
            default: ;
        endcase
    endfunction

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [31:0] imm);
        in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_shamt = sh; in_imm = imm;
    endtask

    // One clock: record what the coming edge will accept, then advance.
    task automatic step();
        logic [31:0] w0, w1;
        int          n;
        bit          bad;
        @(negedge clock);
        if (reset) begin
            sb.delete();
            exp_addr = BASE;
            exp_err  = 1'b0;
        end else begin
            chk("err", 64'(err), 64'(exp_err));
            if (restart) exp_addr = BASE;
            bad = 0;
            if (in_valid && in_ready) begin
                ref_enc(in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, w0, w1, n, bad);
                sb.push_back('{w: w0, a: exp_addr});
                exp_addr += 64'd4;
                if (n == 2) begin
                    sb.push_back('{w: w1, a: exp_addr});
                    exp_addr += 64'd4;
                end
            end
            if (bad)          exp_err = 1'b1;
            else if (restart) exp_err = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    // Output monitor
    initial begin
        exp_t        e;
        logic        prev_hold;
        logic [31:0] prev_w;
        logic [63:0] prev_a;
        prev_hold = 1'b0; prev_w = 32'h0; prev_a = 64'h0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    chk("stable_word", 64'(out_word), 64'(prev_w));
                    chk("stable_addr", out_addr, prev_a);
                end
                prev_hold = out_valid && !out_ready;
                prev_w    = out_word;
                prev_a    = out_addr;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %h at %h, want no word", out_word, out_addr);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_word", 64'(out_word), 64'(e.w));
                        chk("sb_addr", out_addr, e.a);
                    end
                end
            end
        end
    end

    logic [5:0]  burst_op [6];
    logic [31:0] burst_imm[6];
    logic [31:0] burst_exp[6];

    initial begin
        logic [5:0] u;
        enc_op_t    eop;

        reset = 1'b1; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 6'h0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_shamt = 5'd0;
        in_imm = 32'h0;
        exp_addr = BASE; exp_err = 1'b0;

        for (int i = 0; i < 64; i++) legal_map[i] = 0;
        eop = eop.first();
        forever begin
            legal.push_back(eop);
            legal_map[eop] = 1;
            if (eop == eop.last()) break;
            eop = eop.next();
        end

        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_word",  64'(out_word),  64'd0);
        chk("rst_out_addr",  out_addr,       BASE);
        chk("rst_err",       64'(err),       64'd0);
        reset = 1'b0;

        // R-type right after reset
        drive(ENC_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);
        step();
        in_valid = 1'b0;
        chk("addu_valid", 64'(out_valid), 64'd1);
        chk("addu_word",  64'(out_word),  64'h0022_1821);
        chk("addu_addr",  out_addr,       BASE);

        // Two-word LI under backpressure
        drive(ENC_LI, 5'd0, 5'd8, 5'd0, 5'd0, 32'h1234_5678);
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("lui_word", 64'(out_word), 64'h3C08_1234);
        chk("lui_addr", out_addr, BASE + 64'd4);
        repeat (3) begin
            chk("li_stall_rdy", 64'(in_ready), 64'd0);
            step();
            chk("li_stall_word", 64'(out_word), 64'h3C08_1234);
        end
        out_ready = 1'b1;
        chk("li_pend_rdy", 64'(in_ready), 64'd0);
        step();
        chk("ori_word", 64'(out_word), 64'h3508_5678);
        chk("ori_addr", out_addr, BASE + 64'd8);

        // Single-word LI variants and a mixed stream at full rate
        burst_op[0] = ENC_LI;      burst_imm[0] = 32'h0000_0042; burst_exp[0] = 32'h3408_0042;
        burst_op[1] = ENC_LI;      burst_imm[1] = 32'h0001_0000; burst_exp[1] = 32'h3C08_0001;
        burst_op[2] = ENC_BEQ;     burst_imm[2] = 32'h0000_FFFF; burst_exp[2] = 32'h1022_FFFF;
        burst_op[3] = ENC_J;       burst_imm[3] = 32'h0010_0000; burst_exp[3] = 32'h0810_0000;
        burst_op[4] = ENC_ERET;    burst_imm[4] = 32'h0;         burst_exp[4] = 32'h4200_0018;
        burst_op[5] = ENC_SYSCALL; burst_imm[5] = 32'h0;         burst_exp[5] = 32'h0000_000C;
        for (int i = 0; i < 6; i++) begin
            drive(burst_op[i], (i == 2) ? 5'd1 : 5'd0, (i < 2) ? 5'd8 : ((i == 2) ? 5'd2 : 5'd0),
                  5'd0, 5'd0, burst_imm[i]);
            chk("burst_rdy", 64'(in_ready), 64'd1);
            step();
            chk("burst_word", 64'(out_word), 64'(burst_exp[i]));
            chk("burst_addr", out_addr, BASE + 64'd12 + 64'(4 * i));
        end
        in_valid = 1'b0;

        // Unknown op, then restart together with its out handshake
        drive(6'h3F, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
        step();
        in_valid = 1'b0;
        chk("bad_word", 64'(out_word), 64'd0);
        chk("bad_err",  64'(err),      64'd1);
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("restart_err", 64'(err), 64'd0);
        drive(ENC_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);
        step();
        in_valid = 1'b0;
        chk("restart_word", 64'(out_word), 64'h0022_1821);
        chk("restart_addr", out_addr, BASE);

        // Reset while the ORI half is pending
        drive(ENC_LI, 5'd0, 5'd8, 5'd0, 5'd0, 32'h1234_5678);
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        chk("pend_rdy", 64'(in_ready), 64'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_out_valid", 64'(out_valid), 64'd0);
        chk("rst2_in_ready",  64'(in_ready),  64'd1);
        chk("rst2_out_word",  64'(out_word),  64'd0);
        chk("rst2_out_addr",  out_addr,       BASE);
        out_ready = 1'b1;
        repeat (3) step();
        chk("rst2_no_ori", 64'(out_valid), 64'd0);

        // Randomized stream
        for (int c = 0; c < 2000; c++) begin
            int r;
            r = $urandom_range(0, 99);
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 70);
            if (r < 4) begin
                do u = 6'($urandom); while (legal_map[u]);
                in_op = u;
            end else if (r < 30) begin
                in_op = ENC_LI;
            end else begin
                in_op = legal[$urandom_range(0, legal.size() - 1)];
            end
            in_rs = 5'($urandom); in_rt = 5'($urandom);
            in_rd = 5'($urandom); in_shamt = 5'($urandom);
            case ($urandom_range(0, 3))
                0:       in_imm = $urandom & 32'h0000_FFFF;
                1:       in_imm = $urandom & 32'hFFFF_0000;
                default: in_imm = $urandom;
            endcase
            step();
        end

        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        chk("drain_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_insn_encoder.md
# mips_insn_encoder

Streaming MIPS64 instruction encoder and program loader: accepts symbolic instruction requests (mnemonic enum plus register and immediate fields) over a valid/ready handshake. It emits the encoded 32-bit instruction words, each paired with an auto-incrementing instruction-memory address. It expands the `LI` and `NOP` pseudo-ops. It is the write-side counterpart of the core's decoder: it feeds instruction memory from the boot/debug path and produces stimulus words for decoder benches.

## Interface
- `BASE_ADDR`, default `64'h0`: address of the first emitted word and the restart value.
- `ADDR_W`, default `64`: width of `out_addr`.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `restart` in 1: reload the address counter to `BASE_ADDR` and clear `err`.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when `in_valid && in_ready`.
- `in_op` in 6: `enc_op_t` mnemonic.
- `in_rs`, `in_rt`, `in_rd`, `in_shamt` in 5 each: register and shift fields.
- `in_imm` in 32: imm16 in `[15:0]`, J target in `[25:0]`, full constant for `LI`.
- `out_valid` out 1: encoded word valid.
- `out_ready` in 1: consumer takes the word when `out_valid && out_ready`.
- `out_word` out 32: encoded instruction.
- `out_addr` out ADDR_W: address of `out_word`.
- `err` out 1: sticky; set when an unknown `in_op` is accepted.

## Operation
- **Supported ops and encodings**
  - R-type: `ADD ADDU SUB SUBU AND OR XOR NOR SLT SLTU SLL SRL SRA JR JALR DADD DADDU DSUB` encode as `{OP_OTHER0, rs, rt, rd, shamt, funct}`.
  - I-type: `ADDI ADDIU DADDI DADDIU SLTI SLTIU ANDI ORI XORI LUI BEQ BNE LB LBU LW LWU LD SB SW SD` encode as `{op, rs, rt, imm[15:0]}`.
  - J-type: `J JAL` encode as `{op, imm[25:0]}`.
  - Fixed words: `SYSCALL` = `32'h0000000C`; `ERET` = `{OP_Z0, OP_CO, 19'b0, OPC_ERET}` = `32'h42000018`; `NOP` = `32'h0`.
- **LI expansion** (`LI rt, imm32`)
  - `imm[31:16]==0`: one word, `ORI rt,$0,imm[15:0]`.
  - Otherwise: `LUI rt,imm[31:16]`, then `ORI rt,rt,imm[15:0]` only if `imm[15:0]!=0`.
- **Unknown `in_op`**: emit `NOP`; set `err`.
- **FSM**
  - `S_IDLE`: output register empty or being drained.
  - `S_HOLD`: output register full, no pending word.
  - `S_PEND`: output register holds the `LUI` half; the `ORI` half is latched internally.
  - Transitions:
    - Accept of a single-word request → `S_HOLD`.
    - Accept of a two-word `LI` → `S_PEND`.
    - `S_PEND` + out handshake → second word loaded → `S_HOLD`.
    - `S_HOLD` + out handshake with no accept → `S_IDLE`.
    - `S_HOLD` + out handshake with accept → stays `S_HOLD` (or goes to `S_PEND` for a two-word `LI`).
- **Address counter**: advances by 4 on every out handshake. A word's address is fixed when it loads into the output register.
- `in_ready = (state != S_PEND) && (!out_valid || out_ready)`.

## Timing
- **Reset values**: `out_valid=0`, `in_ready=1`, `out_word=0`, `out_addr=BASE_ADDR`, `err=0`, state `S_IDLE`, counter `BASE_ADDR`.
- **Latency**: accept at edge N → `out_valid` and the word at N+1.
- **Throughput**: one word per cycle while `out_ready=1`. A two-word `LI` blocks input for exactly one extra cycle.
- **Stability**: `out_word` and `out_addr` are held stable while `out_valid && !out_ready`.
- **`restart` with an out handshake in the same cycle**: the current word completes with its old address. The next loaded word gets `BASE_ADDR`.
- **`restart` in `S_PEND`**: the pending `ORI` is still emitted, at `BASE_ADDR`.
- **`restart` with an accept of an unknown op**: `err` ends at 1; the set wins over the clear.
- **`reset` mid-`LI`**: the pending word is discarded and all outputs return to reset values next cycle.
- `in_valid` is not required to stay high; requests are not retained across a deasserted `in_valid`.

## Structure
- The `enc_op_t` enum (6 bits) and format-class constants (`FMT_R/I/J/FIXED/PSEUDO`) go in the shared `mips_define` package, alongside the existing opcode/funct localparams.
- Sub-module `mips_encode_word`: purely combinational. Maps `(op, fields)` to `(word, second_word, two_words, illegal)`. The FSM, address counter and handshake stay in `mips_insn_encoder`.

## Test plan
- **R-type after reset**: `ADDU rd=3 rs=1 rt=2`, `out_ready=1` → `out_word=32'h00221821` at `out_addr=BASE_ADDR` one cycle later.
- **Two-word LI with backpressure**: `LI rt=8 imm=32'h12345678`, `out_ready` low 3 cycles → `32'h3C081234` held stable at `BASE`, `in_ready=0` throughout. Then `32'h35085678` at `BASE+4`.
- **LI variants**: `imm=32'h00000042` → single `32'h34080042`; `imm=32'h00010000` → single `32'h3C080001`. `in_ready` never drops for an extra cycle.
- **Mixed stream at full rate**: `BEQ rs=1 rt=2 imm=16'hFFFF` → `32'h1022FFFF`; `J imm=26'h0100000` → `32'h08100000`; `ERET` → `32'h42000018`; `SYSCALL` → `32'h0000000C`. Back-to-back words at addresses `BASE`, `+4`, `+8`, `+12`.
- **Error and restart**: unknown `in_op=6'h3F` → `NOP` emitted, `err=1`. `restart` asserted with a simultaneous out handshake → the next word is at `BASE_ADDR` and `err=0`.
- **Reset in `S_PEND`**: assert `reset` while an `LI` is pending → no `ORI` word appears, `out_valid=0`, `in_ready=1`.
